// File: rtl/signal_generator_sequencer_pkg.sv
// Shared types for the signal generator sequencer: config map, waveform types,
// sequencer states and the config bus payload.
package sig_gen_pkg;

  localparam int unsigned CFG_ADDR_W = 3;
  localparam int unsigned CFG_DATA_W = 32;
  localparam int unsigned TYPE_W     = 4;
  localparam int unsigned TRAP_W     = 16;

  typedef enum logic [CFG_ADDR_W-1:0] {
    CFG_TYPE      = 3'd0,
    CFG_PHASE_INC = 3'd1,
    CFG_TRAP_A    = 3'd2,
    CFG_TRAP_INC  = 3'd3,
    CFG_TARGET    = 3'd4,
    CFG_RAMP_STEP = 3'd5,
    CFG_RSVD      = 3'd6,
    CFG_COMMIT    = 3'd7
  } cfg_addr_e;

  typedef enum logic [TYPE_W-1:0] {
    SIG_TRAPEZOID = 4'd1,
    SIG_TRIANGLE  = 4'd2,
    SIG_SAWTOOTH  = 4'd3
  } sig_type_e;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_ARM           = 3'd1,
    ST_RAMP_UP       = 3'd2,
    ST_RUN           = 3'd3,
    ST_RAMP_DOWN_ADJ = 3'd4,
    ST_RAMP_DOWN     = 3'd5
  } state_e;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } cfg_req_t;

endpackage

// File: rtl/signal_generator_sequencer_if.sv
// Configuration write bus: valid/ready handshake carrying an address/data payload.
interface signal_generator_sequencer_if;
  import sig_gen_pkg::*;

  logic     cfg_valid;
  logic     cfg_ready;
  cfg_req_t cfg_req;

  modport master (output cfg_valid, output cfg_req, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_req, output cfg_ready);

endinterface

// File: rtl/signal_generator_sequencer_amp_ramp.sv
// Amplitude register that steps toward a target with saturation; a zero step
// jumps straight to the target. Done flag reports the stepped value hits target.
module amp_ramp #(
  parameter int unsigned AMP_WIDTH  = 16,
  parameter int unsigned RAMP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  i_clear,
  input  logic                  i_step_en,
  input  logic                  i_up,
  input  logic [AMP_WIDTH-1:0]  i_target,
  input  logic [RAMP_WIDTH-1:0] i_step,
  output logic [AMP_WIDTH-1:0]  o_amp,
  output logic                  o_done_c
);

  localparam int unsigned EXT_W = ((AMP_WIDTH > RAMP_WIDTH) ? AMP_WIDTH : RAMP_WIDTH) + 1;

  logic [AMP_WIDTH-1:0] r_amp;
  logic [AMP_WIDTH-1:0] w_up_val;
  logic [AMP_WIDTH-1:0] w_dn_val;
  logic [AMP_WIDTH-1:0] w_next;
  logic [EXT_W-1:0]     w_amp_x;
  logic [EXT_W-1:0]     w_tgt_x;
  logic [EXT_W-1:0]     w_step_x;
  logic [EXT_W-1:0]     w_sum_x;
  logic [EXT_W-1:0]     w_diff_x;
  logic                 w_step_zero;

  assign w_amp_x     = EXT_W'(r_amp);
  assign w_tgt_x     = EXT_W'(i_target);
  assign w_step_x    = EXT_W'(i_step);
  assign w_step_zero = (i_step == '0);
  assign w_sum_x     = w_amp_x + w_step_x;
  assign w_diff_x    = w_amp_x - w_step_x;

  // Extra headroom bit means the sum never wraps; the borrow case is caught by the compare.
  assign w_up_val = (w_step_zero || (w_sum_x >= w_tgt_x)) ? i_target : AMP_WIDTH'(w_sum_x);
  assign w_dn_val = (w_step_zero || (w_step_x >= w_amp_x) || (w_diff_x <= w_tgt_x))
                    ? i_target : AMP_WIDTH'(w_diff_x);

  assign w_next   = i_up ? w_up_val : w_dn_val;
  assign o_done_c = (w_next == i_target);
  assign o_amp    = r_amp;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_amp <= '0;
    end else if (i_clear) begin
      r_amp <= '0;
    end else if (i_step_en) begin
      r_amp <= w_next;
    end
  end

endmodule

// File: rtl/signal_generator_sequencer.sv
// Per-channel sequencer: shadowed parameter writes committed on period boundaries,
// amplitude ramp-up/down around start/stop, and generator phase-reset gating.
module signal_generator_sequencer
  import sig_gen_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = 16,
  parameter int unsigned AMP_WIDTH   = 16,
  parameter int unsigned RAMP_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       aresetn,
  signal_generator_sequencer_if.slave cfg,
  input  logic                       i_cmd_start,
  input  logic                       i_cmd_stop,
  input  logic                       i_period_start,
  output logic [TYPE_W-1:0]          o_gen_signal_type,
  output logic [PHASE_WIDTH-1:0]     o_gen_phase_inc,
  output logic [TRAP_W-1:0]          o_gen_trap_a,
  output logic [TRAP_W-1:0]          o_gen_trap_inc,
  output logic [AMP_WIDTH-1:0]       o_gen_amplitude,
  output logic                       o_gen_phase_rst,
  output logic                       o_busy,
  output logic                       o_commit_pending
);

  state_e r_state;
  state_e w_state_nxt;

  logic [TYPE_W-1:0]      r_sh_type;
  logic [PHASE_WIDTH-1:0] r_sh_phase_inc;
  logic [TRAP_W-1:0]      r_sh_trap_a;
  logic [TRAP_W-1:0]      r_sh_trap_inc;
  logic [AMP_WIDTH-1:0]   r_sh_target;
  logic [RAMP_WIDTH-1:0]  r_ramp_step;

  logic [TYPE_W-1:0]      r_act_type;
  logic [PHASE_WIDTH-1:0] r_act_phase_inc;
  logic [TRAP_W-1:0]      r_act_trap_a;
  logic [TRAP_W-1:0]      r_act_trap_inc;
  logic [AMP_WIDTH-1:0]   r_act_target;

  logic r_commit_pending;
  logic r_cfg_ready;
  logic r_phase_rst;
  logic r_busy;

  logic                 w_cfg_fire;
  logic                 w_commit_req;
  logic                 w_apply;
  logic                 w_pending_nxt;
  logic [AMP_WIDTH-1:0] w_tgt_new;
  logic [AMP_WIDTH-1:0] w_ramp_tgt;
  logic [AMP_WIDTH-1:0] w_amp;
  logic                 w_ramp_up;
  logic                 w_ramp_done;
  logic                 w_step_en;
  logic                 w_clear;
  logic                 w_unused_data;
  cfg_addr_e            w_addr;

  assign w_addr        = cfg_addr_e'(cfg.cfg_req.addr);
  assign w_cfg_fire    = cfg.cfg_valid && r_cfg_ready;
  assign w_commit_req  = w_cfg_fire && (w_addr == CFG_COMMIT);
  assign w_apply       = r_commit_pending && ((r_state == ST_IDLE) || i_period_start);
  assign w_pending_nxt = w_commit_req ? 1'b1 : (w_apply ? 1'b0 : r_commit_pending);
  assign w_unused_data = ^cfg.cfg_req.data;

  // Ramp sees the post-commit target so a commit and a step on one boundary compose.
  assign w_tgt_new  = w_apply ? r_sh_target : r_act_target;
  assign w_ramp_tgt = (r_state == ST_RAMP_DOWN) ? '0 : w_tgt_new;
  assign w_ramp_up  = (r_state == ST_ARM) || (r_state == ST_RAMP_UP) ||
                      ((r_state == ST_RUN) && (w_tgt_new > w_amp));

  // Shadow registers; ramp_step is used live and is not part of the commit set.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_sh_type      <= SIG_TRIANGLE;
      r_sh_phase_inc <= '0;
      r_sh_trap_a    <= '0;
      r_sh_trap_inc  <= '0;
      r_sh_target    <= '0;
      r_ramp_step    <= '0;
    end else if (w_cfg_fire) begin
      case (w_addr)
        CFG_TYPE:      r_sh_type      <= cfg.cfg_req.data[TYPE_W-1:0];
        CFG_PHASE_INC: r_sh_phase_inc <= PHASE_WIDTH'(cfg.cfg_req.data);
        CFG_TRAP_A:    r_sh_trap_a    <= cfg.cfg_req.data[TRAP_W-1:0];
        CFG_TRAP_INC:  r_sh_trap_inc  <= cfg.cfg_req.data[TRAP_W-1:0];
        CFG_TARGET:    r_sh_target    <= AMP_WIDTH'(cfg.cfg_req.data);
        CFG_RAMP_STEP: r_ramp_step    <= RAMP_WIDTH'(cfg.cfg_req.data);
        CFG_RSVD:      ;
        CFG_COMMIT:    ;
        default:       ;
      endcase
    end
  end

  // Active registers, commit tracking and status flags.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_act_type       <= SIG_TRIANGLE;
      r_act_phase_inc  <= '0;
      r_act_trap_a     <= '0;
      r_act_trap_inc   <= '0;
      r_act_target     <= '0;
      r_commit_pending <= 1'b0;
      r_cfg_ready      <= 1'b1;
      r_phase_rst      <= 1'b1;
      r_busy           <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_type      <= r_sh_type;
        r_act_phase_inc <= r_sh_phase_inc;
        r_act_trap_a    <= r_sh_trap_a;
        r_act_trap_inc  <= r_sh_trap_inc;
        r_act_target    <= r_sh_target;
      end
      r_commit_pending <= w_pending_nxt;
      r_cfg_ready      <= !w_pending_nxt;
      r_phase_rst      <= (r_state == ST_IDLE);
      r_busy           <= (w_state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_en   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        if (i_cmd_start && !i_cmd_stop) w_state_nxt = ST_ARM;
      end
      ST_ARM, ST_RAMP_UP: begin
        if (i_cmd_stop) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else if (i_period_start) begin
          w_step_en   = 1'b1;
          w_state_nxt = w_ramp_done ? ST_RUN : ST_RAMP_UP;
        end
      end
      ST_RUN: begin
        if (i_cmd_stop) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else if (i_period_start && w_apply && (w_tgt_new != w_amp)) begin
          w_step_en   = 1'b1;
          w_state_nxt = w_ramp_done ? ST_RUN : (w_ramp_up ? ST_RAMP_UP : ST_RAMP_DOWN_ADJ);
        end
      end
      ST_RAMP_DOWN_ADJ: begin
        if (i_cmd_stop) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else if (i_period_start) begin
          w_step_en   = 1'b1;
          w_state_nxt = w_ramp_done ? ST_RUN : ST_RAMP_DOWN_ADJ;
        end
      end
      ST_RAMP_DOWN: begin
        if (i_cmd_start && !i_cmd_stop) begin
          w_state_nxt = ST_RAMP_UP;
        end else if (i_period_start) begin
          w_step_en   = 1'b1;
          w_state_nxt = w_ramp_done ? ST_IDLE : ST_RAMP_DOWN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  amp_ramp #(
    .AMP_WIDTH  (AMP_WIDTH),
    .RAMP_WIDTH (RAMP_WIDTH)
  ) u_amp_ramp (
    .clk       (clk),
    .aresetn   (aresetn),
    .i_clear   (w_clear),
    .i_step_en (w_step_en),
    .i_up      (w_ramp_up),
    .i_target  (w_ramp_tgt),
    .i_step    (r_ramp_step),
    .o_amp     (w_amp),
    .o_done_c  (w_ramp_done)
  );

  assign cfg.cfg_ready       = r_cfg_ready;
  assign o_gen_signal_type   = r_act_type;
  assign o_gen_phase_inc     = r_act_phase_inc;
  assign o_gen_trap_a        = r_act_trap_a;
  assign o_gen_trap_inc      = r_act_trap_inc;
  assign o_gen_amplitude     = w_amp;
  assign o_gen_phase_rst     = r_phase_rst;
  assign o_busy              = r_busy;
  assign o_commit_pending    = r_commit_pending;

endmodule

// File: tb/tb_signal_generator_sequencer.sv
// Bench for signal_generator_sequencer: directed vector table, corner sequences
// and randomized traffic against a behavioural model.
module tb_signal_generator_sequencer;
  import sig_gen_pkg::*;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic cmd_start = 1'b0, cmd_stop = 1'b0, period_start = 1'b0;
  logic [3:0]  gen_type;
  logic [15:0] gen_pinc, gen_ta, gen_ti, gen_amp;
  logic        gen_rst, busy, pend;

  always #5 clk = ~clk;

  signal_generator_sequencer_if cfg_if ();

  signal_generator_sequencer #(.PHASE_WIDTH(16), .AMP_WIDTH(16), .RAMP_WIDTH(16)) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .cfg               (cfg_if),
    .i_cmd_start       (cmd_start),
    .i_cmd_stop        (cmd_stop),
    .i_period_start    (period_start),
    .o_gen_signal_type (gen_type),
    .o_gen_phase_inc   (gen_pinc),
    .o_gen_trap_a      (gen_ta),
    .o_gen_trap_inc    (gen_ti),
    .o_gen_amplitude   (gen_amp),
    .o_gen_phase_rst   (gen_rst),
    .o_busy            (busy),
    .o_commit_pending  (pend)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_ARM, M_UP, M_RUN, M_ADJ, M_DOWN} mmode_e;
  mmode_e m_mode;
  longint m_amp, sh_type, sh_pinc, sh_ta, sh_ti, sh_tgt, sh_step;
  longint a_type, a_pinc, a_ta, a_ti, a_tgt;
  bit m_pend, m_rst, m_busy;

  function automatic longint up_to(longint a, longint s, longint t);
    return (s == 0 || a + s >= t) ? t : a + s;
  endfunction

  function automatic longint dn_to(longint a, longint s, longint t);
    return (s == 0 || a - s <= t) ? t : a - s;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_amp = 0;
    sh_type = 2; sh_pinc = 0; sh_ta = 0; sh_ti = 0; sh_tgt = 0; sh_step = 0;
    a_type = 2; a_pinc = 0; a_ta = 0; a_ti = 0; a_tgt = 0;
    m_pend = 0; m_rst = 1; m_busy = 0;
  endtask

  task automatic model_edge(input bit v, input int a, input longint d,
                            input bit st, input bit sp, input bit pr);
    bit fire, apply, was_idle;
    longint tgt;
    if (!aresetn) begin
      model_reset();
      return;
    end
    fire     = v && !m_pend;
    apply    = m_pend && (m_mode == M_IDLE || pr);
    tgt      = apply ? sh_tgt : a_tgt;
    was_idle = (m_mode == M_IDLE);
    if (sp && m_mode inside {M_ARM, M_UP, M_RUN, M_ADJ}) begin
      m_mode = M_DOWN;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_amp = 0;
          if (st && !sp) m_mode = M_ARM;
        end
        M_ARM, M_UP: if (pr) begin
          m_amp  = up_to(m_amp, sh_step, tgt);
          m_mode = (m_amp == tgt) ? M_RUN : M_UP;
        end
        M_RUN: if (pr && tgt != m_amp) begin
          if (tgt > m_amp) begin
            m_amp  = up_to(m_amp, sh_step, tgt);
            m_mode = (m_amp == tgt) ? M_RUN : M_UP;
          end else begin
            m_amp  = dn_to(m_amp, sh_step, tgt);
            m_mode = (m_amp == tgt) ? M_RUN : M_ADJ;
          end
        end
        M_ADJ: if (pr) begin
          m_amp  = dn_to(m_amp, sh_step, tgt);
          m_mode = (m_amp == tgt) ? M_RUN : M_ADJ;
        end
        M_DOWN: begin
          if (st && !sp) m_mode = M_UP;
          else if (pr) begin
            m_amp = dn_to(m_amp, sh_step, 0);
            if (m_amp == 0) m_mode = M_IDLE;
          end
        end
        default: ;
      endcase
    end
    if (apply) begin
      a_type = sh_type; a_pinc = sh_pinc; a_ta = sh_ta; a_ti = sh_ti; a_tgt = sh_tgt;
    end
    if (fire) begin
      case (a)
        0: sh_type = d & 'hF;
        1: sh_pinc = d & 'hFFFF;
        2: sh_ta   = d & 'hFFFF;
        3: sh_ti   = d & 'hFFFF;
        4: sh_tgt  = d & 'hFFFF;
        5: sh_step = d & 'hFFFF;
        default: ;
      endcase
    end
    if (fire && a == 7) m_pend = 1;
    else if (apply)     m_pend = 0;
    m_rst  = was_idle;
    m_busy = (m_mode != M_IDLE);
  endtask

  task automatic check_model();
    chk("model_amp", gen_amp, m_amp);
    chk("model_busy", busy, m_busy);
    chk("model_phase_rst", gen_rst, m_rst);
    chk("model_pending", pend, m_pend);
    chk("model_cfg_ready", cfg_if.cfg_ready, !m_pend);
    chk("model_type", gen_type, a_type);
    chk("model_phase_inc", gen_pinc, a_pinc);
    chk("model_trap_a", gen_ta, a_ta);
    chk("model_trap_inc", gen_ti, a_ti);
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, sample after it.
  task automatic cycle(input bit v, input int a, input logic [31:0] d,
                       input bit st, input bit sp, input bit pr);
    @(negedge clk);
    cfg_if.cfg_valid    = v;
    cfg_if.cfg_req.addr = 3'(a);
    cfg_if.cfg_req.data = d;
    cmd_start = st; cmd_stop = sp; period_start = pr;
    @(posedge clk);
    model_edge(v, a, longint'(d), st, sp, pr);
    #1;
    check_model();
  endtask

  task automatic wr(input int a, input logic [31:0] d); cycle(1, a, d, 0, 0, 0); endtask
  task automatic idle();  cycle(0, 0, 0, 0, 0, 0); endtask
  task automatic pulse(); cycle(0, 0, 0, 0, 0, 1); endtask
  task automatic start(); cycle(0, 0, 0, 1, 0, 0); endtask
  task automatic stop();  cycle(0, 0, 0, 0, 1, 0); endtask

  typedef struct {
    bit v; int addr; int data; bit st; bit sp; bit pr;
    int e_amp; bit e_busy; bit e_rst; bit e_pend; int e_type; int e_pinc; int e_ta;
  } vec_t;
  vec_t tbl[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 0, 1,    0, 0, 0,    0, 0, 1, 0, 2, 0,   0};
    tbl[1]  = '{1, 1, 300,  0, 0, 0,    0, 0, 1, 0, 2, 0,   0};
    tbl[2]  = '{1, 2, 80,   0, 0, 0,    0, 0, 1, 0, 2, 0,   0};
    tbl[3]  = '{1, 3, 100,  0, 0, 0,    0, 0, 1, 0, 2, 0,   0};
    tbl[4]  = '{1, 4, 8000, 0, 0, 0,    0, 0, 1, 0, 2, 0,   0};
    tbl[5]  = '{1, 5, 2000, 0, 0, 0,    0, 0, 1, 0, 2, 0,   0};
    tbl[6]  = '{1, 7, 0,    0, 0, 0,    0, 0, 1, 1, 2, 0,   0};
    tbl[7]  = '{0, 0, 0,    0, 0, 0,    0, 0, 1, 0, 1, 300, 80};
    tbl[8]  = '{0, 0, 0,    1, 0, 0,    0, 1, 1, 0, 1, 300, 80};
    tbl[9]  = '{0, 0, 0,    0, 0, 0,    0, 1, 0, 0, 1, 300, 80};
    tbl[10] = '{0, 0, 0,    0, 0, 1, 2000, 1, 0, 0, 1, 300, 80};
    tbl[11] = '{0, 0, 0,    0, 0, 1, 4000, 1, 0, 0, 1, 300, 80};
    tbl[12] = '{0, 0, 0,    0, 0, 1, 6000, 1, 0, 0, 1, 300, 80};
    tbl[13] = '{0, 0, 0,    0, 0, 1, 8000, 1, 0, 0, 1, 300, 80};
    tbl[14] = '{1, 4, 5000, 0, 0, 0, 8000, 1, 0, 0, 1, 300, 80};
    tbl[15] = '{1, 7, 0,    0, 0, 0, 8000, 1, 0, 1, 1, 300, 80};
    tbl[16] = '{0, 0, 0,    0, 0, 0, 8000, 1, 0, 1, 1, 300, 80};
    tbl[17] = '{0, 0, 0,    0, 0, 1, 6000, 1, 0, 0, 1, 300, 80};
    tbl[18] = '{0, 0, 0,    0, 0, 1, 5000, 1, 0, 0, 1, 300, 80};
    tbl[19] = '{0, 0, 0,    0, 0, 1, 5000, 1, 0, 0, 1, 300, 80};

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_req   = '0;
    model_reset();

    // reset values
    aresetn = 1'b0;
    idle(); idle();
    chk("reset_amp", gen_amp, 0);
    chk("reset_phase_rst", gen_rst, 1);
    chk("reset_cfg_ready", cfg_if.cfg_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_pending", pend, 0);
    chk("reset_type", gen_type, 2);
    aresetn = 1'b1;

    // directed table: IDLE commit, ramp-up, retarget in RUN
    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].v, tbl[i].addr, 32'(tbl[i].data), tbl[i].st, tbl[i].sp, tbl[i].pr);
      chk($sformatf("tbl%0d_amp", i), gen_amp, tbl[i].e_amp);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_phase_rst", i), gen_rst, tbl[i].e_rst);
      chk($sformatf("tbl%0d_pending", i), pend, tbl[i].e_pend);
      chk($sformatf("tbl%0d_cfg_ready", i), cfg_if.cfg_ready, !tbl[i].e_pend);
      chk($sformatf("tbl%0d_type", i), gen_type, tbl[i].e_type);
      chk($sformatf("tbl%0d_phase_inc", i), gen_pinc, tbl[i].e_pinc);
      chk($sformatf("tbl%0d_trap_a", i), gen_ta, tbl[i].e_ta);
    end

    // stop with step 3000 from 5000
    wr(5, 3000);
    stop();  chk("stop_hold_amp", gen_amp, 5000);
    pulse(); chk("stop_down1_amp", gen_amp, 2000);
    pulse(); chk("stop_down2_amp", gen_amp, 0); chk("stop_idle_busy", busy, 0);
    idle();  chk("stop_phase_rst", gen_rst, 1);

    // restart while ramping down continues from current amplitude
    start(); idle();
    pulse(); chk("arm_step_amp", gen_amp, 3000);
    pulse(); chk("rerun_amp", gen_amp, 5000);
    stop(); pulse(); chk("restart_pre_amp", gen_amp, 2000);
    start(); chk("restart_busy", busy, 1);
    pulse(); chk("restart_amp", gen_amp, 5000);
    pulse(); chk("restart_hold_amp", gen_amp, 5000);

    // start+stop together, then zero step
    cycle(0, 0, 0, 1, 1, 0); chk("both_hold_amp", gen_amp, 5000);
    pulse(); chk("both_down_amp", gen_amp, 2000);
    wr(5, 0);
    pulse(); chk("step0_down_amp", gen_amp, 0); chk("step0_down_busy", busy, 0);
    start(); idle();
    pulse(); chk("step0_up_amp", gen_amp, 5000);
    stop(); pulse(); chk("step0_stop_amp", gen_amp, 0); chk("step0_stop_busy", busy, 0);

    // reset mid ramp-up discards a pending commit
    wr(5, 1000); start(); idle();
    pulse(); chk("rampup_amp", gen_amp, 1000);
    wr(4, 9000); wr(7, 0); chk("pre_reset_pending", pend, 1);
    aresetn = 1'b0;
    idle();
    chk("midrst_amp", gen_amp, 0);
    chk("midrst_phase_rst", gen_rst, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_pending", pend, 0);
    chk("midrst_cfg_ready", cfg_if.cfg_ready, 1);
    chk("midrst_type", gen_type, 2);
    aresetn = 1'b1;
    pulse(); chk("discard_pending", pend, 0); chk("discard_type", gen_type, 2);
    wr(7, 0); idle();
    chk("post_commit_type", gen_type, 2); chk("post_commit_trap_a", gen_ta, 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit v, st, sp, pr;
      int a;
      logic [31:0] d;
      v  = ($urandom_range(0, 99) < 35);
      a  = int'($urandom_range(0, 7));
      if (a == 4)      d = 32'($urandom_range(0, 65535));
      else if (a == 5) d = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 30000));
      else             d = $urandom();
      st = ($urandom_range(0, 99) < 6);
      sp = ($urandom_range(0, 99) < 4);
      pr = ($urandom_range(0, 3) == 0);
      aresetn = ($urandom_range(0, 499) != 0);
      cycle(v, a, d, st, sp, pr);
    end
    aresetn = 1'b1;
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
